// File: rtl/gpac_adc_ser.sv
// gpac_adc_ser: 4-channel 14-bit ADC serializer with frame clock, handshake and underrun tracking.
// Optional ramp test pattern is built in only when GPAC_ADC_SER_TESTPAT_EN is defined.
module gpac_adc_ser #(
  parameter int FCO_HIGH_BITS  = 7,
  parameter int UNDERRUN_CNT_W = 16
) (
  input  logic                      ADC_CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  input  logic                      TEST_MODE,
  input  logic [13:0]               DATA_IN0,
  input  logic [13:0]               DATA_IN1,
  input  logic [13:0]               DATA_IN2,
  input  logic [13:0]               DATA_IN3,
  input  logic                      DATA_VALID,
  output logic                      DATA_READY,
  output logic [3:0]                ADC_OUT,
  output logic                      ADC_FCO,
  output logic                      FRAME_START,
  output logic                      UNDERRUN,
  output logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT
);
  // state   | meaning
  // IDLE    | outputs quiet, waiting for ENABLE
  // PRELOAD | one-cycle fetch of the first sample set, DATA_READY high
  // RUN     | serializing slots 0..13, reloading at slot 13 while enabled
  typedef enum logic [1:0] {IDLE = 2'd0, PRELOAD = 2'd1, RUN = 2'd2} state_t;

  localparam logic [3:0]                LAST_SLOT = 4'd13;
  localparam logic [3:0]                FCO_HI    = 4'(FCO_HIGH_BITS);
  localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [3:0][13:0] shreg, shreg_nxt;
  logic             load;
  logic             test_active;
  logic             underrun_nxt;
  logic [13:0]      ramp_val;
  logic [3:0]       adc_out_nxt;

`ifdef GPAC_ADC_SER_TESTPAT_EN
  logic [13:0] ramp;
  assign test_active = TEST_MODE;
  assign ramp_val    = ramp;

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST)                       ramp <= '0;
    else if (load && test_active)  ramp <= ramp + 14'd1;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = TEST_MODE;
  assign test_active      = 1'b0;
  assign ramp_val         = '0;
`endif

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    load        = 1'b0;
    case (state)
      IDLE: begin
        bit_cnt_nxt = 4'd0;
        if (ENABLE) state_nxt = PRELOAD;
      end
      PRELOAD: begin
        state_nxt   = RUN;
        bit_cnt_nxt = 4'd0;
        load        = 1'b1;
      end
      RUN: begin
        if (bit_cnt == LAST_SLOT) begin
          bit_cnt_nxt = 4'd0;
          if (ENABLE) load = 1'b1;
          else        state_nxt = IDLE;
        end else begin
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = 4'd0;
      end
    endcase
  end

  assign DATA_READY = load && !test_active;

  // A PRELOAD underrun has no earlier sample to repeat, so it sends zeros.
  always_comb begin
    shreg_nxt    = shreg;
    underrun_nxt = 1'b0;
    if (load) begin
      if (test_active) begin
        shreg_nxt = {4{ramp_val}};
      end else if (DATA_VALID) begin
        shreg_nxt = {DATA_IN3, DATA_IN2, DATA_IN1, DATA_IN0};
      end else begin
        underrun_nxt = 1'b1;
        if (state == PRELOAD) shreg_nxt = '0;
      end
    end
  end

  always_comb begin
    adc_out_nxt = '0;
    if (state_nxt == RUN)
      for (int i = 0; i < 4; i++) adc_out_nxt[i] = shreg_nxt[i][LAST_SLOT - bit_cnt_nxt];
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      ADC_OUT      <= '0;
      ADC_FCO      <= 1'b0;
      FRAME_START  <= 1'b0;
      UNDERRUN     <= 1'b0;
      UNDERRUN_CNT <= '0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      ADC_OUT     <= adc_out_nxt;
      ADC_FCO     <= (state_nxt == RUN) && (bit_cnt_nxt < FCO_HI);
      FRAME_START <= (state_nxt == RUN) && (bit_cnt_nxt == 4'd0);
      UNDERRUN    <= underrun_nxt;
      if (underrun_nxt && (UNDERRUN_CNT != CNT_MAX))
        UNDERRUN_CNT <= UNDERRUN_CNT + UNDERRUN_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gpac_adc_ser.sv
// Self-checking bench for gpac_adc_ser: directed frame scenarios plus randomized traffic
// checked every cycle against a slot-position model of the serializer.
module tb_gpac_adc_ser;
  localparam int FCO_HIGH = 7;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int IDLE_POS = 99;
`ifdef GPAC_ADC_SER_TESTPAT_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             RST = 1'b0;
  logic             ENABLE = 1'b0;
  logic             TEST_MODE = 1'b0;
  logic             DATA_VALID = 1'b0;
  logic [13:0]      DATA_IN0 = '0, DATA_IN1 = '0, DATA_IN2 = '0, DATA_IN3 = '0;
  logic             DATA_READY;
  logic [3:0]       ADC_OUT;
  logic             ADC_FCO;
  logic             FRAME_START;
  logic             UNDERRUN;
  logic [CNT_W-1:0] UNDERRUN_CNT;

  int nchk = 0;
  int nerr = 0;

  gpac_adc_ser #(.FCO_HIGH_BITS(FCO_HIGH), .UNDERRUN_CNT_W(CNT_W)) dut (
    .ADC_CLK(clk), .RST(RST), .ENABLE(ENABLE), .TEST_MODE(TEST_MODE),
    .DATA_IN0(DATA_IN0), .DATA_IN1(DATA_IN1), .DATA_IN2(DATA_IN2), .DATA_IN3(DATA_IN3),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .ADC_OUT(ADC_OUT), .ADC_FCO(ADC_FCO),
    .FRAME_START(FRAME_START), .UNDERRUN(UNDERRUN), .UNDERRUN_CNT(UNDERRUN_CNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos is the slot index shown on the outputs this cycle (-1 = preload cycle).
  int          m_pos = IDLE_POS;
  logic [13:0] m_smp [4] = '{default: '0};
  int          m_ramp = 0;
  int          m_cnt = 0;
  logic [3:0]  m_out = '0;
  logic        m_fco = 1'b0, m_fs = 1'b0, m_ur = 1'b0, m_ld;

  function automatic logic m_ready();
    return ((m_pos == -1) || (m_pos == 13 && ENABLE)) && !(TP_EN && TEST_MODE);
  endfunction

  always @(posedge clk or posedge RST) begin
    m_ur = 1'b0;
    if (RST) begin
      m_pos = IDLE_POS;
      for (int i = 0; i < 4; i++) m_smp[i] = '0;
      m_ramp = 0;
      m_cnt  = 0;
    end else begin
      m_ld = (m_pos == -1) || (m_pos == 13 && ENABLE);
      if (m_ld) begin
        if (TP_EN && TEST_MODE) begin
          for (int i = 0; i < 4; i++) m_smp[i] = 14'(m_ramp);
          m_ramp = (m_ramp + 1) % 16384;
        end else if (DATA_VALID) begin
          m_smp[0] = DATA_IN0; m_smp[1] = DATA_IN1; m_smp[2] = DATA_IN2; m_smp[3] = DATA_IN3;
        end else begin
          m_ur = 1'b1;
          if (m_pos == -1) for (int i = 0; i < 4; i++) m_smp[i] = '0;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      if (m_pos == IDLE_POS) m_pos = ENABLE ? -1 : IDLE_POS;
      else if (m_ld)         m_pos = 0;
      else if (m_pos == 13)  m_pos = IDLE_POS;
      else                   m_pos = m_pos + 1;
    end
    m_out = '0; m_fco = 1'b0; m_fs = 1'b0;
    if (m_pos >= 0 && m_pos <= 13) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_smp[i][13 - m_pos];
      m_fco = (m_pos < FCO_HIGH);
      m_fs  = (m_pos == 0);
    end
  end

  always @(negedge clk) begin
    check("adc_out", 32'(ADC_OUT), 32'(m_out));
    check("adc_fco", 32'(ADC_FCO), 32'(m_fco));
    check("frame_start", 32'(FRAME_START), 32'(m_fs));
    check("underrun", 32'(UNDERRUN), 32'(m_ur));
    check("underrun_cnt", 32'(UNDERRUN_CNT), 32'(m_cnt));
    check("data_ready", 32'(DATA_READY), 32'(m_ready()));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_all(input logic [13:0] v);
    DATA_IN0 = v; DATA_IN1 = v; DATA_IN2 = v; DATA_IN3 = v;
  endtask

  // Starts in a slot-0 cycle; returns one cycle after slot 13.
  task automatic collect_frame(input int drop_at, input logic [13:0] nxt, input logic nxt_valid,
                               output logic [3:0][13:0] d, output logic [13:0] fco);
    d = '0; fco = '0;
    for (int k = 0; k < 14; k++) begin
      check("frame_start_slot", 32'(FRAME_START), (k == 0) ? 32'd1 : 32'd0);
      for (int i = 0; i < 4; i++) d[i][13 - k] = ADC_OUT[i];
      fco[13 - k] = ADC_FCO;
      if (k == 0) begin set_all(nxt); DATA_VALID = nxt_valid; end
      if (k == drop_at) ENABLE = 1'b0;
      if (k == 13 && drop_at >= 0) check("ready_after_drop", 32'(DATA_READY), 32'd0);
      step();
    end
  endtask

  logic [3:0][13:0] f1, f2, f3;
  logic [13:0]      fc;

  initial begin
    #1 RST = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_adc_out", 32'(ADC_OUT), 32'd0);
    check("rst_cnt", 32'(UNDERRUN_CNT), 32'd0);
    check("rst_ready", 32'(DATA_READY), 32'd0);
    RST = 1'b0;
    step();

    // Single frame with 14'h2A5C, enable dropped at slot 5
    DATA_IN0 = 14'h2A5C; DATA_IN1 = 14'h0F0F; DATA_IN2 = 14'h0000; DATA_IN3 = 14'h3FFF;
    DATA_VALID = 1'b1; ENABLE = 1'b1;
    step();
    check("preload_ready", 32'(DATA_READY), 32'd1);
    check("preload_no_fs", 32'(FRAME_START), 32'd0);
    step();
    collect_frame(5, 14'h1111, 1'b1, f1, fc);
    check("a_ch0_bits", 32'(f1[0]), 32'(14'b10101001011100));
    check("a_ch1_bits", 32'(f1[1]), 32'h0F0F);
    check("a_ch3_bits", 32'(f1[3]), 32'h3FFF);
    check("a_fco_bits", 32'(fc), 32'h3F80);
    check("a_idle_out", 32'(ADC_OUT), 32'd0);
    check("a_idle_fco", 32'(ADC_FCO), 32'd0);
    check("a_idle_fs", 32'(FRAME_START), 32'd0);
    step();

    // Three back-to-back frames carrying 1, 2, 3
    set_all(14'd1); DATA_VALID = 1'b1; ENABLE = 1'b1;
    step();
    check("b_preload_ready", 32'(DATA_READY), 32'd1);
    step();
    collect_frame(-1, 14'd2, 1'b1, f1, fc);
    collect_frame(-1, 14'd3, 1'b1, f2, fc);
    collect_frame(3, 14'd0, 1'b0, f3, fc);
    check("b_frame1", 32'(f1[0]), 32'd1);
    check("b_frame2", 32'(f2[2]), 32'd2);
    check("b_frame3", 32'(f3[3]), 32'd3);
    check("b_idle_fs", 32'(FRAME_START), 32'd0);
    step();

    // Underrun at the second load repeats frame 1
    set_all(14'h1357); DATA_VALID = 1'b1; ENABLE = 1'b1;
    step(); step();
    collect_frame(-1, 14'h0AAA, 1'b0, f1, fc);
    check("c_underrun_pulse", 32'(UNDERRUN), 32'd1);
    check("c_underrun_cnt", 32'(UNDERRUN_CNT), 32'd1);
    collect_frame(4, 14'h0555, 1'b1, f2, fc);
    check("c_frame1", 32'(f1[1]), 32'h1357);
    check("c_repeat", 32'(f2[1]), 32'h1357);
    check("c_underrun_done", 32'(UNDERRUN), 32'd0);
    step();

    // Async reset at slot 8, then restart through PRELOAD
    set_all(14'h3FFF); DATA_VALID = 1'b1; ENABLE = 1'b1;
    step(); step();
    repeat (8) step();
    check("d_before_rst_out", 32'(ADC_OUT), 32'hF);
    check("d_before_rst_cnt", 32'(UNDERRUN_CNT), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("d_rst_out", 32'(ADC_OUT), 32'd0);
    check("d_rst_fco", 32'(ADC_FCO), 32'd0);
    check("d_rst_fs", 32'(FRAME_START), 32'd0);
    check("d_rst_cnt", 32'(UNDERRUN_CNT), 32'd0);
    check("d_rst_ready", 32'(DATA_READY), 32'd0);
    step();
    RST = 1'b0;
    check("d_idle_ready", 32'(DATA_READY), 32'd0);
    step();
    check("d_preload_ready", 32'(DATA_READY), 32'd1);
    check("d_preload_out", 32'(ADC_OUT), 32'd0);
    step();
    check("d_restart_fs", 32'(FRAME_START), 32'd1);
    check("d_restart_out", 32'(ADC_OUT), 32'hF);
    ENABLE = 1'b0;
    repeat (16) step();

`ifdef GPAC_ADC_SER_TESTPAT_EN
    // Ramp frames 0, 1, 2 with no handshake and no underrun
    RST = 1'b1; step(); RST = 1'b0;
    TEST_MODE = 1'b1; DATA_VALID = 1'b0; ENABLE = 1'b1;
    step();
    check("e_preload_ready", 32'(DATA_READY), 32'd0);
    step();
    collect_frame(-1, 14'h1555, 1'b0, f1, fc);
    collect_frame(-1, 14'h1555, 1'b0, f2, fc);
    collect_frame(2, 14'h1555, 1'b0, f3, fc);
    check("e_ramp0", 32'(f1[0]), 32'd0);
    check("e_ramp1", 32'(f2[3]), 32'd1);
    check("e_ramp2", 32'(f3[1]), 32'd2);
    check("e_no_underrun", 32'(UNDERRUN_CNT), 32'd0);
    TEST_MODE = 1'b0;
    step();
`endif

    // Randomized traffic checked against the model every cycle
    ENABLE = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 599) == 0) RST = 1'b1;
      if ($urandom_range(0, 24) == 0) ENABLE = ~ENABLE;
      if ($urandom_range(0, 59) == 0) TEST_MODE = ~TEST_MODE;
      DATA_VALID = ($urandom_range(0, 9) < 7);
      DATA_IN0 = 14'($urandom); DATA_IN1 = 14'($urandom);
      DATA_IN2 = 14'($urandom); DATA_IN3 = 14'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
